// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus between the execute/memory units and the write-port arbiter.
// One valid/ready lane per requester with packed destination address and data.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// write stage and a pending-write scoreboard for decode RAW-hazard stalls.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    rf_wb_arbiter_if.slave       req,
    input  logic                 wb_hold,
    input  logic                 issue_en,
    input  logic [4:0]           issue_addr,
    input  logic [4:0]           chk_addrA,
    input  logic [4:0]           chk_addrB,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [31:0]          wr_data
);
    logic [PW-1:0]   rr_ptr;
    logic [31:0]     pending;
    logic [31:0]     pending_nxt;

    logic [4:0]      addr_arr [NREQ];
    logic [31:0]     data_arr [NREQ];

    logic [NREQ-1:0] ready_p0;
    logic            gnt_vld_p0;
    logic [PW-1:0]   gnt_idx_p0;
    logic [4:0]      gnt_addr_p0;
    logic [31:0]     gnt_data_p0;
    logic [PW:0]     scan_sum;
    logic [PW-1:0]   scan_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req.req_addr[5*i +: 5];
        assign data_arr[i] = req.req_data[32*i +: 32];
    end

    // Stage p0: combinational grant, scanning upward from rr_ptr with wraparound
    always_comb begin
        ready_p0    = '0;
        gnt_vld_p0  = 1'b0;
        gnt_idx_p0  = '0;
        gnt_addr_p0 = '0;
        gnt_data_p0 = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        if (nrst && !wb_hold) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
                if (scan_sum >= (PW+1)'(NREQ))
                    scan_sum = scan_sum - (PW+1)'(NREQ);
                scan_idx = scan_sum[PW-1:0];
                if (!gnt_vld_p0 && req.req_valid[scan_idx]) begin
                    gnt_vld_p0          = 1'b1;
                    gnt_idx_p0          = scan_idx;
                    gnt_addr_p0         = addr_arr[scan_idx];
                    gnt_data_p0         = data_arr[scan_idx];
                    ready_p0[scan_idx]  = 1'b1;
                end
            end
        end
    end

    assign req.req_ready = ready_p0;

    // A newly issued producer outranks a same-cycle retirement of the older one
    always_comb begin
        pending_nxt = pending;
        if (gnt_vld_p0)
            pending_nxt[gnt_addr_p0] = 1'b0;
        if (issue_en)
            pending_nxt[issue_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Stage p1: registered write port, pointer and scoreboard
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr  <= '0;
            pending <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            pending <= pending_nxt;
            if (gnt_vld_p0) begin
                rr_ptr  <= (gnt_idx_p0 == PW'(NREQ-1)) ? '0 : gnt_idx_p0 + PW'(1);
                wr_en   <= (gnt_addr_p0 != 5'd0);
                wr_addr <= gnt_addr_p0;
                wr_data <= gnt_data_p0;
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

    // The write sitting in the output stage is not yet readable from the register file
    assign busy_a = pending[chk_addrA] | (wr_en & (wr_addr == chk_addrA) & (chk_addrA != 5'd0));
    assign busy_b = pending[chk_addrB] | (wr_en & (wr_addr == chk_addrB) & (chk_addrB != 5'd0));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of grant order, write stage and scoreboard.
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int PW   = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        wb_hold = 1'b0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [4:0]  chk_addrA = '0;
    logic [4:0]  chk_addrB = '0;
    logic        busy_a, busy_b, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int failures = 0;

    rf_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
        .clk(clk), .nrst(nrst), .req(bus.slave), .wb_hold(wb_hold),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .chk_addrA(chk_addrA), .chk_addrB(chk_addrB),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Behavioural model: pointer as an integer, scoreboard as a set of busy registers
    int          m_ptr;
    bit [31:0]   m_pend;
    bit          m_wr_en;
    bit [4:0]    m_wr_addr;
    bit [31:0]   m_wr_data;

    function automatic void model_reset();
        m_ptr = 0; m_pend = '0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    endfunction

    function automatic int m_grant();
        if (wb_hold) return -1;
        for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int g = m_grant();
        return (g < 0) ? '0 : NREQ'(1 << g);
    endfunction

    function automatic bit m_busy(logic [4:0] a);
        return m_pend[a] || (m_wr_en && m_wr_addr == a && a != 0);
    endfunction

    function automatic void model_edge();
        int g = m_grant();
        logic [4:0] a;
        if (g >= 0) begin
            a = bus.req_addr[5*g +: 5];
            m_wr_en = (a != 0);
            m_wr_addr = a;
            m_wr_data = bus.req_data[32*g +: 32];
            m_ptr = (g + 1) % NREQ;
            m_pend[a] = 1'b0;
        end else begin
            m_wr_en = 1'b0;
        end
        if (issue_en) m_pend[issue_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_req(int i, bit v, logic [4:0] a, logic [31:0] d);
        bus.req_valid[i] = v;
        bus.req_addr[5*i +: 5] = a;
        bus.req_data[32*i +: 32] = d;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0; wb_hold = 0; issue_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        #3;
        nrst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = NREQ'($urandom); bus.req_addr = 15'($urandom);
            bus.req_data = {$urandom, $urandom, $urandom};
            wb_hold = 1'($urandom); issue_en = 1'b1; issue_addr = 5'($urandom);
            chk_addrA = issue_addr; chk_addrB = 5'($urandom);
            #1;
            checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
            checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
            checks++; if (wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
            checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
            checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy_a, busy_b); end
            @(posedge clk);
            @(negedge clk);
        end
        clear_inputs();
        nrst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_idle_wr_en got=%0h exp=0", wr_en); end
        end
    endtask

    task automatic test_single();
        set_req(0, 1, 5'd5, 32'hDEADBEEF);
        #1;
        checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_write got=%0h/%0d/%h exp=1/5/deadbeef", wr_en, wr_addr, wr_data); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_wr_en_drop got=%0h exp=0", wr_en); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 5'(10 + i), 32'hA0 + i);
        for (int k = 0; k < NREQ; k++) begin
            #1;
            checks++; if (bus.req_ready !== NREQ'(1 << k)) begin failures++; $display("FAIL rr_withdraw_grant%0d got=%b exp=%b", k, bus.req_ready, NREQ'(1 << k)); end
            tick();
            bus.req_valid[k] = 1'b0;
            checks++; if (wr_en !== 1'b1 || wr_addr !== 5'(10 + k)) begin failures++; $display("FAIL rr_withdraw_write%0d got=%0h/%0d exp=1/%0d", k, wr_en, wr_addr, 10 + k); end
        end
        bus.req_valid = '1;
        for (int k = 0; k < 2 * NREQ; k++) begin
            #1;
            checks++; if (bus.req_ready !== NREQ'(1 << (k % NREQ))) begin failures++; $display("FAIL rr_cont_grant%0d got=%b exp=%b", k, bus.req_ready, NREQ'(1 << (k % NREQ))); end
            tick();
            checks++; if (wr_addr !== 5'(10 + k % NREQ) || wr_data !== 32'hA0 + (k % NREQ)) begin failures++; $display("FAIL rr_cont_write%0d got=%0d/%h exp=%0d", k, wr_addr, wr_data, 10 + k % NREQ); end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_x0();
        chk_addrA = 5'd0;
        set_req(1, 1, 5'd0, 32'h1234);
        issue_en = 1'b1; issue_addr = 5'd0;
        #1;
        checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", bus.req_ready); end
        tick();
        bus.req_valid = '0; issue_en = 1'b0;
        checks++; if (wr_en !== 1'b0 || wr_data !== 32'h1234) begin failures++; $display("FAIL x0_write got=%0h/%h exp=0/1234", wr_en, wr_data); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0h exp=0", busy_a); end
    endtask

    task automatic test_scoreboard();
        chk_addrA = 5'd7; chk_addrB = 5'd9;
        issue_en = 1'b1; issue_addr = 5'd7;
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL sb_t0 got=%0h exp=0", busy_a); end
        tick();
        issue_en = 1'b0;
        checks++; if (busy_a !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL sb_t1 got=%b%b exp=10", busy_a, busy_b); end
        tick();
        set_req(0, 1, 5'd7, 32'h77);
        #1;
        checks++; if (busy_a !== 1'b1 || bus.req_ready !== 3'b001) begin failures++; $display("FAIL sb_t3 got=%0h/%b exp=1/001", busy_a, bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (busy_a !== 1'b1 || wr_en !== 1'b1) begin failures++; $display("FAIL sb_t4 got=%0h/%0h exp=1/1", busy_a, wr_en); end
        tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL sb_t5 got=%0h exp=0", busy_a); end
        issue_en = 1'b1;
        tick();
        set_req(1, 1, 5'd7, 32'h78);
        tick();
        issue_en = 1'b0; bus.req_valid = '0; chk_addrB = 5'd7;
        tick();
        checks++; if (wr_en !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%0h/%b%b exp=0/11", wr_en, busy_a, busy_b); end
        set_req(2, 1, 5'd7, 32'h79);
        tick();
        bus.req_valid = '0;
        tick();
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL sb_final_clear got=%b%b exp=00", busy_a, busy_b); end
    endtask

    task automatic test_hold_reset();
        set_req(0, 1, 5'd20, 32'h20);
        tick();
        wb_hold = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 5'(20 + i), 32'h20 + i);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL hold_ready%0d got=%b exp=000", c, bus.req_ready); end
            tick();
            checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL hold_wr_en%0d got=%0h exp=0", c, wr_en); end
        end
        wb_hold = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL hold_release got=%b exp=010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        issue_en = 1'b1; issue_addr = 5'd3;
        set_req(0, 1, 5'd4, 32'h44);
        tick();
        issue_en = 1'b0; bus.req_valid = '0;
        chk_addrA = 5'd3; chk_addrB = 5'd4;
        #1;
        checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin failures++; $display("FAIL midrst_before got=%b%b exp=11", busy_a, busy_b); end
        set_req(1, 1, 5'd5, 32'h55);
        nrst = 1'b0;
        model_reset();
        #1;
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || wr_en !== 1'b0 || bus.req_ready !== 3'b000) begin
            failures++; $display("FAIL midrst_during got=%b%b/%0h/%b exp=00/0/000", busy_a, busy_b, wr_en, bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        bus.req_valid = '0;
        tick();
        checks++; if (busy_a !== 1'b0 || wr_en !== 1'b0 || wr_data !== 32'd0) begin failures++; $display("FAIL midrst_after got=%0h/%0h/%h exp=0/0/0", busy_a, wr_en, wr_data); end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && ($urandom % 3 == 0))
                    set_req(i, 1, 5'($urandom_range(0, 7)), $urandom);
            wb_hold = ($urandom % 5 == 0);
            issue_en = ($urandom % 3 == 0);
            issue_addr = 5'($urandom_range(0, 7));
            chk_addrA = 5'($urandom_range(0, 7));
            chk_addrB = 5'($urandom_range(0, 7));
            #1;
            checks++; if (bus.req_ready !== m_ready()) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, m_ready()); end
            checks++; if (busy_a !== m_busy(chk_addrA) || busy_b !== m_busy(chk_addrB)) begin
                failures++; $display("FAIL rand_busy c=%0d got=%b%b exp=%b%b", c, busy_a, busy_b, m_busy(chk_addrA), m_busy(chk_addrB)); end
            g = m_grant();
            tick();
            if (g >= 0) bus.req_valid[g] = 1'b0;
            checks++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
                failures++; $display("FAIL rand_write c=%0d got=%0h/%0d/%h exp=%0h/%0d/%h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_x0();
        test_scoreboard();
        test_hold_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
